// File: rtl/mod_exp_pkg.sv
// rtl/mod_exp_pkg.sv - shared width default and FSM state encoding for mod_exp_seq
//
// Purpose: constants shared by mod_exp_seq and its mod_mul datapath.
// Ports:   none (package).
package mod_exp_pkg;

  localparam int DEFAULT_WIDTH = 19;

  // FSM state encoding for the top-level sequencer
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REDUCE = 3'd1;
  localparam logic [2:0] S_SQUARE = 3'd2;
  localparam logic [2:0] S_MULT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

endpackage

// File: rtl/mod_exp_seq_mod_mul.sv
// rtl/mod_exp_seq_mod_mul.sv - interleaved shift-add modular multiplier (a*b mod n)
//
// Purpose: computes p = a*b mod n in WIDTH+1 cycles: one load cycle (go=1)
//          followed by WIDTH double-and-add steps, MSB-first over b.
//          Requires a < n; b may be any WIDTH-bit value.
// Ports:   clk, rst  - clock, synchronous active-high reset
//          go        - load a, b, n and start (ignored bits of a busy op are restarted)
//          a, b, n   - addend operand, multiplier operand, modulus
//          p         - product register; holds the final value until the next go
//          rdy       - high during the final step cycle; p is valid from the next cycle
module mod_mul
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             rdy
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, b_q, n_q, p_q;
  logic [CW-1:0]    cnt;
  logic             active;

  // One WIDTH+1-bit guard bit is enough: p < n, so 2p < 2n and (2p mod n) + a < 2n.
  logic [WIDTH:0]   n_ext, dbl, sum;
  logic [WIDTH-1:0] dbl_red, sum_red;

  always_comb begin
    n_ext   = {1'b0, n_q};
    dbl     = {p_q, 1'b0};
    dbl_red = (dbl >= n_ext) ? WIDTH'(dbl - n_ext) : dbl[WIDTH-1:0];
    sum     = {1'b0, dbl_red} + (b_q[WIDTH-1] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    sum_red = (sum >= n_ext) ? WIDTH'(sum - n_ext) : sum[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      p_q    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (go) begin
      a_q    <= a;
      b_q    <= b;
      n_q    <= n;
      p_q    <= '0;
      cnt    <= CW'(WIDTH);
      active <= 1'b1;
    end else if (active) begin
      p_q <= sum_red;
      b_q <= b_q << 1;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) active <= 1'b0;
    end
  end

  assign p   = p_q;
  assign rdy = active && (cnt == CW'(1));

endmodule

// File: rtl/mod_exp_seq.sv
// rtl/mod_exp_seq.sv - sequential left-to-right modular exponentiation (base^exponent mod modulus)
//
// Purpose: latches operands on start, reduces base mod n, then scans every
//          exponent bit MSB-first doing square (and multiply when the bit is 1)
//          through a single shared mod_mul.
// Ports:   clk, rst                 - clock, synchronous active-high reset
//          start                    - request, sampled only in IDLE
//          base, exponent, modulus  - unsigned WIDTH-bit operands
//          result                   - registered base^exponent mod modulus (0 on error)
//          busy                     - high from the cycle after accept until done
//          done                     - one-cycle completion pulse
//          error                    - pulses with done when modulus < 2
module mod_exp_seq
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2:0]       state;
  logic [WIDTH-1:0] base_q, exp_q, n_q;
  logic [WIDTH-1:0] acc;     // running accumulator
  logic [WIDTH-1:0] bp;      // base reduced mod n
  logic [IW-1:0]    idx;
  logic             first;   // first cycle of an op state: issue go to mod_mul
  logic             from_reduce;
  logic             err_q;

  logic             go, mm_rdy, n_ok;
  logic [WIDTH-1:0] mm_a, mm_b, mm_p, sq_src;

  assign n_ok = (n_q > WIDTH'(1));

  // mod_mul's p register still holds the previous op's result during the
  // load cycle of the next op, so operands come straight from it rather
  // than waiting a cycle for acc/bp to be captured. Only the first square
  // uses acc (=1), because p then holds b' instead.
  assign sq_src = from_reduce ? acc : mm_p;

  always_comb begin
    go   = 1'b0;
    mm_a = '0;
    mm_b = '0;
    case (state)
      S_REDUCE: begin
        go   = first && n_ok;
        mm_a = WIDTH'(1);
        mm_b = base_q;
      end
      S_SQUARE: begin
        go   = first;
        mm_a = sq_src;
        mm_b = sq_src;
      end
      S_MULT: begin
        go   = first;
        mm_a = mm_p;
        mm_b = bp;
      end
      default: ;
    endcase
  end

  mod_mul #(.WIDTH(WIDTH)) u_mod_mul (
    .clk (clk),
    .rst (rst),
    .go  (go),
    .a   (mm_a),
    .b   (mm_b),
    .n   (n_q),
    .p   (mm_p),
    .rdy (mm_rdy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      base_q      <= '0;
      exp_q       <= '0;
      n_q         <= '0;
      acc         <= '0;
      bp          <= '0;
      idx         <= '0;
      first       <= 1'b0;
      from_reduce <= 1'b0;
      err_q       <= 1'b0;
      result      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q      <= base;
            exp_q       <= exponent;
            n_q         <= modulus;
            idx         <= IW'(WIDTH - 1);
            acc         <= WIDTH'(1);
            first       <= 1'b1;
            from_reduce <= 1'b0;
            err_q       <= 1'b0;
            busy        <= 1'b1;
            state       <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          if (first && !n_ok) begin
            err_q <= 1'b1;
            first <= 1'b0;
            state <= S_FINISH;
          end else begin
            first <= 1'b0;
            if (mm_rdy) begin
              first       <= 1'b1;
              from_reduce <= 1'b1;
              state       <= S_SQUARE;
            end
          end
        end
        S_SQUARE, S_MULT: begin
          if (first) begin
            first <= 1'b0;
            if (from_reduce) begin
              bp          <= mm_p;
              from_reduce <= 1'b0;
            end else begin
              acc <= mm_p;
            end
          end
          if (mm_rdy) begin
            first <= 1'b1;
            if (state == S_SQUARE && exp_q[idx]) begin
              state <= S_MULT;
            end else if (idx == '0) begin
              state <= S_FINISH;
            end else begin
              idx   <= idx - 1'b1;
              state <= S_SQUARE;
            end
          end
        end
        S_FINISH: begin
          result <= err_q ? '0 : mm_p;
          acc    <= err_q ? '0 : mm_p;
          done   <= 1'b1;
          error  <= err_q;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_seq.sv
// tb/tb_mod_exp_seq.sv - self-checking bench for mod_exp_seq against an arithmetic reference
module tb_mod_exp_seq;

  localparam int W = 19;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] base, exponent, modulus;
  logic [W-1:0] result;
  logic         busy, done, error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_exp_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  // Right-to-left binary exponentiation with 64-bit arithmetic.
  function automatic longint ref_modexp(longint b, longint e, longint n);
    longint r, x, k;
    if (n < 2) return 0;
    r = 1;
    x = b % n;
    k = e;
    while (k > 0) begin
      if ((k & 1) != 0) r = (r * x) % n;
      x = (x * x) % n;
      k = k >> 1;
    end
    return r % n;
  endfunction

  function automatic int ref_latency(logic [W-1:0] e, logic [W-1:0] n);
    if (n < 2) return 2;
    return (1 + W + $countones(e)) * (W + 1) + 1;
  endfunction

  // Called #1 after a rising edge. Returns edges from accept to done (capped).
  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n,
                        output int lat, output logic saw_busy);
    base = b; exponent = e; modulus = n; start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    saw_busy = busy;
    base     = W'($urandom);
    exponent = W'($urandom);
    modulus  = W'($urandom);
    lat = 0;
    while (!done && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %0d expected 0", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b expected 0", error); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [W-1:0] b, e, n, res;
    int           lat;
  } vec_t;

  task automatic test_vectors();
    vec_t v[4];
    int   lat;
    logic sb;
    v[0] = '{b: 19'd4,      e: 19'd13, n: 19'd497,    res: 19'd445, lat: 461};
    v[1] = '{b: 19'd500,    e: 19'd1,  n: 19'd497,    res: 19'd3,   lat: 421};
    v[2] = '{b: 19'd524287, e: 19'd2,  n: 19'd524287, res: 19'd0,   lat: 421};
    v[3] = '{b: 19'd7,      e: 19'd0,  n: 19'd11,     res: 19'd1,   lat: 401};
    foreach (v[i]) begin
      run_op(v[i].b, v[i].e, v[i].n, lat, sb);
      checks++; if (sb !== 1'b1) begin errors++; $display("FAIL vec%0d_busy got %b expected 1", i, sb); end
      checks++; if (result !== v[i].res) begin errors++; $display("FAIL vec%0d_result got %0d expected %0d", i, result, v[i].res); end
      checks++; if (lat != v[i].lat) begin errors++; $display("FAIL vec%0d_latency got %0d expected %0d", i, lat, v[i].lat); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL vec%0d_error got %b expected 0", i, error); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL vec%0d_pulse done=%b busy=%b expected 0 0", i, done, busy); end
      checks++; if (result !== v[i].res) begin errors++; $display("FAIL vec%0d_hold got %0d expected %0d", i, result, v[i].res); end
    end
  endtask

  task automatic test_error();
    int   lat;
    logic sb;
    for (int m = 0; m < 2; m++) begin
      run_op(W'($urandom), W'($urandom), W'(m), lat, sb);
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_mod%0d_error got %b expected 1", m, error); end
      checks++; if (result !== '0) begin errors++; $display("FAIL err_mod%0d_result got %0d expected 0", m, result); end
      checks++; if (lat != 2) begin errors++; $display("FAIL err_mod%0d_latency got %0d expected 2", m, lat); end
      @(posedge clk); #1;
      // leave a nonzero result so the next error run proves result is cleared
      run_op(19'd3, 19'd4, 19'd50, lat, sb);
      checks++; if (result !== 19'd31) begin errors++; $display("FAIL err_recover%0d got %0d expected 31", m, result); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] b, e, n;
    longint       exp_res;
    int           lat;
    logic         sb;
    for (int i = 0; i < 10; i++) begin
      b = W'($urandom);
      e = (i == 0) ? {W{1'b1}} : W'($urandom);
      n = (i == 0) ? {W{1'b1}} : W'($urandom_range(2, (1 << W) - 1));
      exp_res = ref_modexp(longint'(b), longint'(e), longint'(n));
      run_op(b, e, n, lat, sb);
      checks++; if (result !== W'(exp_res)) begin errors++; $display("FAIL rand%0d_result b=%0d e=%0d n=%0d got %0d expected %0d", i, b, e, n, result, exp_res); end
      checks++; if (lat != ref_latency(e, n)) begin errors++; $display("FAIL rand%0d_latency got %0d expected %0d", i, lat, ref_latency(e, n)); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL rand%0d_error got %b expected 0", i, error); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int   cyc, ndone, done_cyc, lat;
    logic sb;
    base = 19'd2; exponent = 19'd10; modulus = 19'd1000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; done_cyc = -1;
    for (cyc = 1; cyc <= 1000; cyc++) begin
      if (cyc == 50) begin
        base = 19'd3; exponent = 19'd7; modulus = 19'd999; start = 1'b1;
      end else if (cyc == 51) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          checks++; if (result !== 19'd24) begin errors++; $display("FAIL b2b_result got %0d expected 24", result); end
          // next cycle is the one after done: restart must be accepted there
          @(posedge clk); #1;
          run_op(19'd3, 19'd5, 19'd1000, lat, sb);
          checks++; if (sb !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got %b expected 1", sb); end
          checks++; if (result !== 19'd243) begin errors++; $display("FAIL b2b_restart_result got %0d expected 243", result); end
          checks++; if (lat != ref_latency(19'd5, 19'd1000)) begin errors++; $display("FAIL b2b_restart_latency got %0d expected %0d", lat, ref_latency(19'd5, 19'd1000)); end
          break;
        end
      end
    end
    checks++; if (done_cyc != ref_latency(19'd10, 19'd1000)) begin errors++; $display("FAIL b2b_latency got %0d expected %0d", done_cyc, ref_latency(19'd10, 19'd1000)); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL b2b_done_count got %0d expected 1", ndone); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int   ndone, lat;
    logic sb;
    base = 19'd4; exponent = 19'd13; modulus = 19'd497; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", busy); end
    checks++; if (result !== '0) begin errors++; $display("FAIL midrst_result got %0d expected 0", result); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b expected 0", done); end
    ndone = 0;
    repeat (500) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_spurious_done got %0d expected 0", ndone); end
    // reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1; base = 19'd5; exponent = 19'd3; modulus = 19'd7;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_priority_busy got %b expected 0", busy); end
    run_op(19'd4, 19'd13, 19'd497, lat, sb);
    checks++; if (result !== 19'd445) begin errors++; $display("FAIL postrst_result got %0d expected 445", result); end
    checks++; if (lat != 461) begin errors++; $display("FAIL postrst_latency got %0d expected 461", lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_error();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_exp_seq.md
MOD_EXP_SEQ -- requirements
Module: mod_exp_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 19, giving the operand, modulus and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-005 The block SHALL have port base, input, WIDTH bits: message or ciphertext operand, unsigned.
REQ-006 The block SHALL have port exponent, input, WIDTH bits: public or private key exponent, unsigned.
REQ-007 The block SHALL have port modulus, input, WIDTH bits: RSA modulus n, unsigned.
REQ-008 The block SHALL have port result, output, WIDTH bits: base^exponent mod modulus, registered.
REQ-009 The block SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port error, output, 1 bit: pulses together with done when modulus < 2.

Function
REQ-012 The block SHALL have the states IDLE, REDUCE, SQUARE, MULT and FINISH.
REQ-013 In IDLE with start=1, the block SHALL latch base, exponent and modulus, set the bit index to WIDTH-1 and set accumulator to 1; later input changes SHALL be ignored.
REQ-014 If the latched modulus is 0 or 1, the block SHALL go to FINISH without computing, with result=0 and error=1.
REQ-015 Otherwise, REDUCE SHALL compute b' = base mod modulus by running the mod_mul sub-module as 1 * base mod n.
REQ-016 The block SHALL scan exponent bits MSB-first over all WIDTH bits, with no leading-zero skip:
- SQUARE: acc = acc*acc mod n.
- MULT: acc = acc*b' mod n, entered only if the current bit is 1.
- Then the index decrements; after bit 0 the block goes to FINISH.
REQ-017 Each mod_mul operation SHALL take exactly WIDTH+1 cycles: 1 load cycle plus WIDTH interleaved shift-add steps, MSB-first over the multiplier.
- Each step: p = 2p, subtract n if p >= n; if the multiplier bit is set, p = p + a, subtract n if p >= n.
REQ-018 Internal partial sums SHALL be WIDTH+1 bits wide, so no overflow occurs for any n < 2^WIDTH; both operands SHALL be < n at mod_mul entry.
REQ-019 FINISH SHALL last one cycle: result <= acc (or 0 on error), done=1, busy=0, then return to IDLE.
REQ-020 Latency from the start-accept edge to done SHALL be exactly (1 + WIDTH + popcount(exponent)) * (WIDTH+1) + 1 cycles; the error path SHALL take exactly 2 cycles.
REQ-021 start while busy SHALL be ignored; start in the same cycle as done's FINISH SHALL be ignored; start in the cycle after done SHALL be accepted.
REQ-022 exponent = 0 SHALL give result 1 for any modulus >= 2.
REQ-023 result SHALL hold its value until the next FINISH.

Reset
REQ-024 On rst=1, the block SHALL enter IDLE and clear result, busy, done, error and all internal registers on the next edge, including mid-operation.
REQ-025 rst SHALL take priority over start in the same cycle.

Structure
REQ-026 Package mod_exp_pkg SHALL hold the WIDTH default and the state enumeration.
REQ-027 The modular multiply SHALL be one sub-module, mod_mul, with clk, rst, go, a, b, n, p and rdy ports.
- It is reused for REDUCE, SQUARE and MULT.
- The top-level holds the FSM, the bit index, the latched operands and the accumulator.

Verification (WIDTH=19)
REQ-028 base=4, exponent=13, modulus=497 -> result=445, done exactly 461 cycles after start, error=0.
REQ-029 base=500, exponent=1, modulus=497 -> result=3 (base pre-reduced); base=524287, exponent=2, modulus=524287 -> result=0.
REQ-030 base=7, exponent=0, modulus=11 -> result=1, latency 401 cycles; modulus=1 -> error=1, done, result=0, 2 cycles.
REQ-031 Back-to-back and ignored start:
- start 2^10 mod 1000, change inputs and pulse start while busy -> result=24 only, single done.
- Restart on the cycle after done -> accepted.
REQ-032 Reset mid-operation and after reset:
- rst at cycle 100 of an operation -> next cycle busy=0, result=0, no done.
- A following start completes correctly.
